// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start/data/parity/stop sequencing with
// 3-sample majority voting, error flags and a one-cycle data_valid strobe.

package parameters_pkg;
  parameter int DATA_WIDTH = 8;
  parameter int PRESCALE_W = 6;
endpackage

// state  | meaning
// IDLE   | line idle, waiting for a low level to begin a frame
// START  | timing the start bit, rejecting it if it reads back high
// DATA   | shifting in DATA_WIDTH bits, LSB first
// PARITY | comparing the parity bit against the received data
// STOP   | checking the stop bit and publishing a good byte
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = parameters_pkg::DATA_WIDTH,
  parameter int PRESCALE_W = parameters_pkg::PRESCALE_W
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RX_IN,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic [PRESCALE_W-1:0]         Prescale,
  input  logic [PRESCALE_W-1:0]         edge_cnt,
  input  logic [$clog2(DATA_WIDTH):0]   bit_cnt,
  output logic                          edg_bit_cnt_en,
  output logic [DATA_WIDTH-1:0]         P_DATA,
  output logic                          data_valid,
  output logic                          par_err,
  output logic                          stp_err,
  output logic                          strt_glitch
);

  localparam int BCW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [2:0]            samples;

  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last;
  logic                  bit_end;
  logic                  bit_val;
  logic                  data_last;
  logic                  par_exp;

  assign half      = Prescale >> 1;
  assign last      = Prescale - PRESCALE_W'(1);
  assign bit_end   = edg_bit_cnt_en && (edge_cnt == last);
  assign bit_val   = (samples[0] & samples[1]) |
                     (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);
  assign data_last = (bit_cnt == BCW'(DATA_WIDTH));
  assign par_exp   = (^shreg) ^ par_typ_q;

  // Three oversamples around mid-bit; all are settled before the bit end.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samples <= '0;
    end else if (edg_bit_cnt_en) begin
      if (edge_cnt == half - PRESCALE_W'(1)) samples[0] <= RX_IN;
      if (edge_cnt == half)                  samples[1] <= RX_IN;
      if (edge_cnt == half + PRESCALE_W'(1)) samples[2] <= RX_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      edg_bit_cnt_en <= 1'b0;
      P_DATA         <= '0;
      data_valid     <= 1'b0;
      par_err        <= 1'b0;
      stp_err        <= 1'b0;
      strt_glitch    <= 1'b0;
      shreg          <= '0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      strt_glitch <= 1'b0;
      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state          <= START;
            edg_bit_cnt_en <= 1'b1;
            par_en_q       <= PAR_EN;
            par_typ_q      <= PAR_TYP;
            par_err        <= 1'b0;
            stp_err        <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            if (bit_val) begin
              strt_glitch    <= 1'b1;
              state          <= IDLE;
              edg_bit_cnt_en <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
            if (data_last) state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_end) begin
            if (bit_val != par_exp) par_err <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!bit_val) begin
              stp_err <= 1'b1;
            end else if (!par_err) begin
              P_DATA     <= shreg;
              data_valid <= 1'b1;
            end
            state          <= IDLE;
            edg_bit_cnt_en <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          edg_bit_cnt_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: models the edge/bit counter, drives serial
// frames and scoreboards every data_valid strobe against expected bytes.

module tb_uart_rx_frame_ctrl;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       edg_bit_cnt_en;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       strt_glitch;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int dv_count = 0;
  int dv_cyc = 0;
  int glitch_count = 0;
  int glitch_cyc = 0;
  int start_cyc = 0;
  logic prev_dv = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  uart_rx_frame_ctrl dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .Prescale(Prescale),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt),
    .edg_bit_cnt_en(edg_bit_cnt_en),
    .P_DATA(P_DATA),
    .data_valid(data_valid),
    .par_err(par_err),
    .stp_err(stp_err),
    .strt_glitch(strt_glitch)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // Edge/bit counter companion: held at zero while disabled.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!edg_bit_cnt_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == Prescale - 6'd1) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      if (data_valid) begin
        dv_count++;
        dv_cyc = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL dv_unexpected: P_DATA=%h, required no data_valid", P_DATA);
        end else begin
          exp_v = exp_q.pop_front();
          if (P_DATA !== exp_v) begin
            n_err++;
            $display("FAIL dv_data: P_DATA=%h, required %h", P_DATA, exp_v);
          end
        end
        n_cmp++;
        if (prev_dv) begin
          n_err++;
          $display("FAIL dv_pulse_width: data_valid high 2 cycles, required 1");
        end
      end
      if (strt_glitch) begin
        glitch_count++;
        glitch_cyc = cyc;
      end
    end
    prev_dv = data_valid;
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input int p);
    RX_IN = v;
    wait_cycles(p);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    wait_cycles(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic flip_par, input logic stop_v, input int p);
    logic [7:0] dd;
    dd       = d;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    Prescale = 6'(p);
    start_cyc = cyc;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(dd[i], p);
    if (pe) drive_bit((^dd) ^ pt ^ flip_par, p);
    drive_bit(stop_v, p);
  endtask

  task automatic test_reset;
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    wait_cycles(3);
    n_cmp++; if (edg_bit_cnt_en !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b, expected 0", edg_bit_cnt_en); end
    n_cmp++; if (P_DATA !== 8'h00) begin n_err++; $display("FAIL rst_pdata: got %h, expected 00", P_DATA); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_dv: got %b, expected 0", data_valid); end
    n_cmp++; if (par_err !== 1'b0) begin n_err++; $display("FAIL rst_par_err: got %b, expected 0", par_err); end
    n_cmp++; if (stp_err !== 1'b0) begin n_err++; $display("FAIL rst_stp_err: got %b, expected 0", stp_err); end
    n_cmp++; if (strt_glitch !== 1'b0) begin n_err++; $display("FAIL rst_glitch: got %b, expected 0", strt_glitch); end
    RST = 1'b1;
    idle(5);
    n_cmp++; if (edg_bit_cnt_en !== 1'b0) begin n_err++; $display("FAIL idle_en: got %b, expected 0", edg_bit_cnt_en); end
  endtask

  task automatic test_parity_ok;
    int d0;
    d0 = dv_count;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8);
    idle(6);
    n_cmp++; if (dv_count - d0 !== 1) begin n_err++; $display("FAIL par_ok_dv_count: got %0d, expected 1", dv_count - d0); end
    n_cmp++; if (dv_cyc - start_cyc !== 11 * 8 + 1) begin n_err++; $display("FAIL par_ok_latency: got %0d, expected %0d", dv_cyc - start_cyc, 11 * 8 + 1); end
    n_cmp++; if (P_DATA !== 8'hA5) begin n_err++; $display("FAIL par_ok_pdata: got %h, expected a5", P_DATA); end
    n_cmp++; if (par_err !== 1'b0) begin n_err++; $display("FAIL par_ok_par_err: got %b, expected 0", par_err); end
    n_cmp++; if (stp_err !== 1'b0) begin n_err++; $display("FAIL par_ok_stp_err: got %b, expected 0", stp_err); end
  endtask

  task automatic test_parity_err;
    int d0;
    d0 = dv_count;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8);
    idle(6);
    n_cmp++; if (par_err !== 1'b1) begin n_err++; $display("FAIL par_err_flag: got %b, expected 1", par_err); end
    n_cmp++; if (stp_err !== 1'b0) begin n_err++; $display("FAIL par_err_stp: got %b, expected 0", stp_err); end
    n_cmp++; if (dv_count - d0 !== 0) begin n_err++; $display("FAIL par_err_dv: got %0d pulses, expected 0", dv_count - d0); end
    n_cmp++; if (P_DATA !== 8'hA5) begin n_err++; $display("FAIL par_err_pdata: got %h, expected a5", P_DATA); end
  endtask

  task automatic test_stop_err;
    int d0;
    d0 = dv_count;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16);
    idle(6);
    n_cmp++; if (stp_err !== 1'b1) begin n_err++; $display("FAIL stp_err_flag: got %b, expected 1", stp_err); end
    n_cmp++; if (par_err !== 1'b0) begin n_err++; $display("FAIL stp_err_par: got %b, expected 0", par_err); end
    n_cmp++; if (dv_count - d0 !== 0) begin n_err++; $display("FAIL stp_err_dv: got %0d pulses, expected 0", dv_count - d0); end
    n_cmp++; if (P_DATA !== 8'hA5) begin n_err++; $display("FAIL stp_err_pdata: got %h, expected a5", P_DATA); end
  endtask

  task automatic test_start_glitch;
    int d0, g0;
    d0 = dv_count;
    g0 = glitch_count;
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    start_cyc = cyc;
    drive_bit(1'b0, 2);
    idle(14);
    n_cmp++; if (glitch_count - g0 !== 1) begin n_err++; $display("FAIL glitch_count: got %0d, expected 1", glitch_count - g0); end
    n_cmp++; if (glitch_cyc - start_cyc !== 9) begin n_err++; $display("FAIL glitch_time: got %0d, expected 9", glitch_cyc - start_cyc); end
    n_cmp++; if (edg_bit_cnt_en !== 1'b0) begin n_err++; $display("FAIL glitch_en: got %b, expected 0", edg_bit_cnt_en); end
    n_cmp++; if (dv_count - d0 !== 0) begin n_err++; $display("FAIL glitch_dv: got %0d pulses, expected 0", dv_count - d0); end
    n_cmp++; if (stp_err !== 1'b0) begin n_err++; $display("FAIL glitch_stp: got %b, expected 0", stp_err); end
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = dv_count;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 32);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 32);
    idle(8);
    n_cmp++; if (dv_count - d0 !== 2) begin n_err++; $display("FAIL b2b_dv_count: got %0d, expected 2", dv_count - d0); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL b2b_queue: %0d bytes left, expected 0", exp_q.size()); end
    n_cmp++; if (P_DATA !== 8'hC3) begin n_err++; $display("FAIL b2b_pdata: got %h, expected c3", P_DATA); end
    n_cmp++; if (stp_err !== 1'b0 || par_err !== 1'b0) begin n_err++; $display("FAIL b2b_errs: got par=%b stp=%b, expected 0 0", par_err, stp_err); end
  endtask

  task automatic test_reset_mid_frame;
    int d0;
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 4);
    n_cmp++; if (edg_bit_cnt_en !== 1'b1) begin n_err++; $display("FAIL mid_en_active: got %b, expected 1", edg_bit_cnt_en); end
    #2;
    RST = 1'b0;
    #1;
    n_cmp++; if (edg_bit_cnt_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_en: got %b, expected 0", edg_bit_cnt_en); end
    n_cmp++; if (P_DATA !== 8'h00) begin n_err++; $display("FAIL mid_rst_pdata: got %h, expected 00", P_DATA); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_dv: got %b, expected 0", data_valid); end
    n_cmp++; if (par_err !== 1'b0 || stp_err !== 1'b0 || strt_glitch !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_flags: got par=%b stp=%b glitch=%b, expected 0 0 0", par_err, stp_err, strt_glitch);
    end
    RX_IN = 1'b1;
    wait_cycles(2);
    RST = 1'b1;
    idle(12);
    n_cmp++; if (edg_bit_cnt_en !== 1'b0) begin n_err++; $display("FAIL post_rst_idle: got %b, expected 0", edg_bit_cnt_en); end
    d0 = dv_count;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    idle(6);
    n_cmp++; if (dv_count - d0 !== 1) begin n_err++; $display("FAIL post_rst_dv: got %0d pulses, expected 1", dv_count - d0); end
    n_cmp++; if (P_DATA !== 8'h5A) begin n_err++; $display("FAIL post_rst_pdata: got %h, expected 5a", P_DATA); end
  endtask

  initial begin
    test_reset();
    test_parity_ok();
    test_parity_err();
    test_stop_err();
    test_start_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
